// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sweep sequencer: mode encodings, sweep
// state enum and default word widths.
package awg_pkg;

   localparam int unsigned FREQ_W_DEF  = 16;
   localparam int unsigned DWELL_W_DEF = 24;

   // cfg_mode encodings; 2'b11 is treated as single
   localparam logic [1:0] MODE_SINGLE   = 2'b00;
   localparam logic [1:0] MODE_REPEAT   = 2'b01;
   localparam logic [1:0] MODE_TRIANGLE = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      DWELL,
      STEP_WAIT,
      DONE
   } sweep_state_t;

endpackage

// File: rtl/awg_sweep_stepper.sv
// Combinational next-point computation for the sweep sequencer.
// Ports:
//   cur, step, start, stop : current point, step size, sweep endpoints
//   dir                    : current travel direction (1 = increasing)
//   mode                   : sweep mode
//   next_freq, next_dir    : following point and its travel direction
//   at_end                 : cur sits on the endpoint of the current leg
module awg_sweep_stepper
   import awg_pkg::*;
#(
   parameter int unsigned FREQ_W = FREQ_W_DEF
) (
   input  logic [FREQ_W-1:0] cur,
   input  logic [FREQ_W-1:0] step,
   input  logic [FREQ_W-1:0] start,
   input  logic [FREQ_W-1:0] stop,
   input  logic              dir,
   input  logic [1:0]        mode,
   output logic [FREQ_W-1:0] next_freq,
   output logic              next_dir,
   output logic              at_end
);

   logic [FREQ_W-1:0] lo;
   logic [FREQ_W-1:0] hi;
   logic [FREQ_W-1:0] leg_target;
   logic [FREQ_W-1:0] new_target;
   logic [FREQ_W:0]   sum;
   logic [FREQ_W:0]   diff;
   logic              toggle;
   logic              restart;

   // Leg endpoint follows the direction: upward legs end at the larger
   // endpoint, downward legs at the smaller one. Extra bit catches carry
   // and borrow so the result clamps instead of wrapping.
   always_comb begin
      lo         = (start <= stop) ? start : stop;
      hi         = (start <= stop) ? stop  : start;
      leg_target = dir ? hi : lo;
      at_end     = (cur == leg_target);
      toggle     = (mode == MODE_TRIANGLE) && at_end;
      restart    = (mode == MODE_REPEAT) && at_end;
      next_dir   = toggle ? ~dir : dir;
      new_target = next_dir ? hi : lo;
      sum        = {1'b0, cur} + {1'b0, step};
      diff       = {1'b0, cur} - {1'b0, step};
      if (restart) begin
         next_freq = start;
      end else if (next_dir) begin
         next_freq = (sum > {1'b0, new_target}) ? new_target : sum[FREQ_W-1:0];
      end else begin
         next_freq = (diff[FREQ_W] || (diff[FREQ_W-1:0] < new_target)) ?
                     new_target : diff[FREQ_W-1:0];
      end
   end

endmodule

// File: rtl/awg_sweep_sequencer.sv
// Frequency-sweep scheduler feeding the waveform generator's frequency word.
// Passes manual_freq through when idle; otherwise steps from start to stop
// with a minimum dwell per point, applying each change on a phase wrap.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   manual_freq       : pass-through frequency word when idle
//   cfg_*             : sweep configuration, latched on an accepted start
//   start, abort      : control pulses (abort has priority)
//   phase_wrap        : generator phase-accumulator wrap pulse
//   freq_out          : registered frequency word to the generator
//   sweep_active      : high from accepted start until return to idle
//   step_strobe       : pulse with each sweep-point load of freq_out
//   sweep_done        : pulse on single-sweep completion
//   cfg_err           : pulse when a start is rejected (zero step)
module awg_sweep_sequencer
   import awg_pkg::*;
#(
   parameter int unsigned FREQ_W  = FREQ_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FREQ_W-1:0]  manual_freq,
   input  logic [FREQ_W-1:0]  cfg_start_freq,
   input  logic [FREQ_W-1:0]  cfg_stop_freq,
   input  logic [FREQ_W-1:0]  cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic               start,
   input  logic               abort,
   input  logic               phase_wrap,
   output logic [FREQ_W-1:0]  freq_out,
   output logic               sweep_active,
   output logic               step_strobe,
   output logic               sweep_done,
   output logic               cfg_err
);

   sweep_state_t       state;
   logic [FREQ_W-1:0]  start_q;
   logic [FREQ_W-1:0]  stop_q;
   logic [FREQ_W-1:0]  step_q;
   logic [FREQ_W-1:0]  next_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] cnt;
   logic [1:0]         mode_q;
   logic               dir_q;

   logic [FREQ_W-1:0]  next_freq_c;
   logic               next_dir_c;
   logic               at_end_c;
   logic               is_single_c;

   assign is_single_c = (mode_q != MODE_REPEAT) && (mode_q != MODE_TRIANGLE);

   // freq_out holds the current point throughout DWELL, so it is the stepper's cur
   awg_sweep_stepper #(
      .FREQ_W (FREQ_W)
   ) u_stepper (
      .cur       (freq_out),
      .step      (step_q),
      .start     (start_q),
      .stop      (stop_q),
      .dir       (dir_q),
      .mode      (mode_q),
      .next_freq (next_freq_c),
      .next_dir  (next_dir_c),
      .at_end    (at_end_c)
   );

   // Sweep FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         start_q      <= '0;
         stop_q       <= '0;
         step_q       <= '0;
         next_q       <= '0;
         dwell_q      <= '0;
         cnt          <= '0;
         mode_q       <= '0;
         dir_q        <= 1'b0;
         freq_out     <= '0;
         sweep_active <= 1'b0;
         step_strobe  <= 1'b0;
         sweep_done   <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         step_strobe <= 1'b0;
         sweep_done  <= 1'b0;
         cfg_err     <= 1'b0;
         if (abort && (state != IDLE)) begin
            // freq_out holds one more cycle; IDLE then reloads manual_freq
            state        <= IDLE;
            sweep_active <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  freq_out <= manual_freq;
                  if (start && !abort) begin
                     if (cfg_step == '0) begin
                        cfg_err <= 1'b1;
                     end else begin
                        start_q      <= cfg_start_freq;
                        stop_q       <= cfg_stop_freq;
                        step_q       <= cfg_step;
                        mode_q       <= cfg_mode;
                        dwell_q      <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                        dir_q        <= (cfg_start_freq <= cfg_stop_freq);
                        sweep_active <= 1'b1;
                        state        <= ARM;
                     end
                  end
               end
               ARM: begin
                  if (phase_wrap) begin
                     freq_out    <= start_q;
                     step_strobe <= 1'b1;
                     cnt         <= dwell_q - DWELL_W'(1);
                     state       <= DWELL;
                  end
               end
               DWELL: begin
                  // a wrap coinciding with expiry is not used; STEP_WAIT waits for the next
                  if (cnt == '0) begin
                     if (is_single_c && at_end_c) begin
                        sweep_done <= 1'b1;
                        state      <= DONE;
                     end else begin
                        next_q <= next_freq_c;
                        dir_q  <= next_dir_c;
                        state  <= STEP_WAIT;
                     end
                  end else begin
                     cnt <= cnt - DWELL_W'(1);
                  end
               end
               STEP_WAIT: begin
                  if (phase_wrap) begin
                     freq_out    <= next_q;
                     step_strobe <= 1'b1;
                     cnt         <= dwell_q - DWELL_W'(1);
                     state       <= DWELL;
                  end
               end
               DONE: begin
                  sweep_active <= 1'b0;
                  state        <= IDLE;
               end
               default: begin
                  sweep_active <= 1'b0;
                  state        <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_awg_sweep_sequencer.sv
// Self-checking bench for awg_sweep_sequencer: directed and random sweeps
// compared against a point-list model built from the sweep rules.
`timescale 1ns/1ps
module tb_awg_sweep_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] manual_freq;
   logic [15:0] cfg_start_freq;
   logic [15:0] cfg_stop_freq;
   logic [15:0] cfg_step;
   logic [23:0] cfg_dwell;
   logic [1:0]  cfg_mode;
   logic        start;
   logic        abort;
   logic        phase_wrap;
   logic [15:0] freq_out;
   logic        sweep_active;
   logic        step_strobe;
   logic        sweep_done;
   logic        cfg_err;

   awg_sweep_sequencer #(
      .FREQ_W  (16),
      .DWELL_W (24)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .manual_freq    (manual_freq),
      .cfg_start_freq (cfg_start_freq),
      .cfg_stop_freq  (cfg_stop_freq),
      .cfg_step       (cfg_step),
      .cfg_dwell      (cfg_dwell),
      .cfg_mode       (cfg_mode),
      .start          (start),
      .abort          (abort),
      .phase_wrap     (phase_wrap),
      .freq_out       (freq_out),
      .sweep_active   (sweep_active),
      .step_strobe    (step_strobe),
      .sweep_done     (sweep_done),
      .cfg_err        (cfg_err)
   );

   int checks = 0;
   int errors = 0;
   int got_q[$];
   int exp_q[$];
   int leg_q[$];
   int done_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int last_strobe = -1;
   int cur_dwell = 1;
   int wrap_per = 8;
   int wcnt = 0;
   logic wrap_seen = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Phase-wrap source: one pulse every wrap_per cycles
   initial begin
      phase_wrap = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         wcnt++;
         if (wcnt >= wrap_per) begin
            wcnt = 0;
            phase_wrap = 1'b1;
         end else begin
            phase_wrap = 1'b0;
         end
      end
   end

   // Output monitor: records sweep points, checks wrap alignment and minimum dwell
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (step_strobe) begin
               got_q.push_back(int'(freq_out));
               check("strobe_on_wrap", int'(wrap_seen), 1);
               if (last_strobe >= 0)
                  check("dwell_gap", int'((cyc - last_strobe) > cur_dwell), 1);
               last_strobe = cyc;
            end
            if (sweep_done) done_cnt++;
            if (cfg_err) err_cnt++;
         end
         wrap_seen = phase_wrap;
      end
   end

   // One monotonic leg from a to b, last step clamped onto b
   function automatic void build_leg(input int a, input int b, input int st);
      int v;
      leg_q.delete();
      v = a;
      leg_q.push_back(v);
      while (v != b) begin
         if (b > a) v = (v + st > b) ? b : v + st;
         else       v = (v - st < b) ? b : v - st;
         leg_q.push_back(v);
      end
   endfunction

   // Expected point list; continuous modes are truncated to n points
   function automatic void model_points(input int s, input int p, input int st,
                                        input int mode, input int n);
      bit fwd;
      exp_q.delete();
      build_leg(s, p, st);
      if (mode == 1) begin
         while (exp_q.size() < n)
            foreach (leg_q[i]) exp_q.push_back(leg_q[i]);
      end else if (mode == 2) begin
         if (s == p) begin
            while (exp_q.size() < n) exp_q.push_back(s);
         end else begin
            foreach (leg_q[i]) exp_q.push_back(leg_q[i]);
            fwd = 1'b0;
            while (exp_q.size() < n) begin
               if (fwd) build_leg(s, p, st);
               else     build_leg(p, s, st);
               for (int i = 1; i < leg_q.size(); i++) exp_q.push_back(leg_q[i]);
               fwd = !fwd;
            end
         end
      end else begin
         foreach (leg_q[i]) exp_q.push_back(leg_q[i]);
      end
      if (mode == 1 || mode == 2)
         while (exp_q.size() > n) void'(exp_q.pop_back());
   endfunction

   task automatic kick(input int s, input int p, input int st, input int dw, input int mode);
      @(posedge clk);
      #1;
      cfg_start_freq = 16'(s);
      cfg_stop_freq  = 16'(p);
      cfg_step       = 16'(st);
      cfg_dwell      = 24'(dw);
      cfg_mode       = 2'(mode);
      cur_dwell      = (dw == 0) ? 1 : dw;
      last_strobe    = -1;
      got_q.delete();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_pts(input int n, input int budget);
      int k;
      k = 0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("pts_timeout", int'(got_q.size() >= n), 1);
   endtask

   task automatic cmp_pts(input int n);
      for (int i = 0; i < n; i++)
         check($sformatf("pt%0d", i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
   endtask

   task automatic abort_now();
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
   endtask

   // Single-shot sweep run to completion; optionally pokes a start mid-sweep
   task automatic run_single(input int s, input int p, input int st, input int dw,
                             input int mode, input int wp, input int man, input bit mid);
      int d0;
      int k;
      bit poked;
      d0 = done_cnt;
      wrap_per = wp;
      manual_freq = 16'(man);
      model_points(s, p, st, mode, 0);
      kick(s, p, st, dw, mode);
      k = 0;
      poked = 1'b0;
      while (done_cnt == d0 && k < 4000) begin
         @(negedge clk);
         k++;
         if (mid && !poked && got_q.size() == 2) begin
            poked = 1'b1;
            cfg_start_freq = 16'h1234;
            cfg_stop_freq  = 16'h0100;
            cfg_step       = 16'h0001;
            cfg_mode       = 2'b01;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      check("done_once", done_cnt - d0, 1);
      check("idle_active", int'(sweep_active), 0);
      check("idle_manual", int'(freq_out), man);
      check("npts", got_q.size(), exp_q.size());
      cmp_pts(exp_q.size());
   endtask

   // Continuous sweep: collect n points then abort
   task automatic run_cont(input int s, input int p, input int st, input int dw,
                           input int mode, input int wp, input int man, input int n);
      int d0;
      d0 = done_cnt;
      wrap_per = wp;
      manual_freq = 16'(man);
      model_points(s, p, st, mode, n);
      kick(s, p, st, dw, mode);
      wait_pts(n, 4000);
      abort_now();
      @(negedge clk);
      check("abort_active", int'(sweep_active), 0);
      @(negedge clk);
      check("abort_manual", int'(freq_out), man);
      check("abort_no_done", done_cnt - d0, 0);
      cmp_pts(n);
   endtask

   initial begin
      int e0;
      rst = 1'b1;
      manual_freq = 16'h0042;
      cfg_start_freq = '0;
      cfg_stop_freq = '0;
      cfg_step = '0;
      cfg_dwell = '0;
      cfg_mode = '0;
      start = 1'b0;
      abort = 1'b0;
      #12;
      check("reset_outs", int'({freq_out, sweep_active, step_strobe, sweep_done, cfg_err}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_manual", int'(freq_out), 16'h0042);

      // Directed sweeps
      run_single(100, 130, 10, 4, 0, 8, 16'h0777, 1'b0);
      run_single(50, 20, 20, 3, 0, 5, 16'h1111, 1'b0);
      run_cont(0, 30, 15, 6, 2, 3, 16'h2222, 7);
      run_cont(16'hFFF0, 16'hFFFF, 16'h0008, 2, 1, 4, 16'h3333, 7);
      run_single(7, 7, 1, 0, 3, 2, 16'h4444, 1'b0);
      run_single(100, 160, 20, 3, 0, 5, 16'h5555, 1'b1);

      // Rejected start: zero step
      e0 = err_cnt;
      wrap_per = 4;
      kick(10, 20, 0, 1, 0);
      @(negedge clk);
      check("err_pulse", int'(cfg_err), 1);
      @(negedge clk);
      check("err_width", int'(cfg_err), 0);
      repeat (20) @(negedge clk);
      check("err_cnt", err_cnt - e0, 1);
      check("err_idle", int'(sweep_active), 0);
      check("err_nopts", got_q.size(), 0);

      // start and abort together: abort wins
      @(posedge clk);
      #1;
      cfg_step = 16'd5;
      got_q.delete();
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("sa_active0", int'(sweep_active), 0);
      repeat (20) @(negedge clk);
      check("sa_active1", int'(sweep_active), 0);
      check("sa_nopts", got_q.size(), 0);
      check("sa_noerr", err_cnt - e0, 1);

      // Randomized sweeps
      for (int it = 0; it < 8; it++) begin
         int s;
         int p;
         int span;
         int st;
         int md;
         int dw;
         int wp;
         int man;
         s    = int'($urandom_range(0, 65535));
         p    = (it < 2) ? s : int'($urandom_range(0, 65535));
         span = (s > p) ? s - p : p - s;
         st   = int'($urandom_range(1, 65535));
         if (span / st > 12) st = span / 12 + 1;
         md   = (it == 0) ? 2 : (it == 1) ? 0 : int'($urandom_range(0, 3));
         dw   = int'($urandom_range(0, 5));
         wp   = int'($urandom_range(1, 7));
         man  = int'($urandom_range(0, 65535));
         if (md == 1 || md == 2) run_cont(s, p, st, dw, md, wp, man, 10);
         else                    run_single(s, p, st, dw, md, wp, man, 1'b0);
      end

      // Asynchronous reset while waiting for a wrap between points
      wrap_per = 30;
      manual_freq = 16'h0ABC;
      kick(1000, 2000, 100, 2, 0);
      wait_pts(1, 200);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async", int'({freq_out, sweep_active, step_strobe, sweep_done, cfg_err}), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_manual", int'(freq_out), 16'h0ABC);
      check("rst_idle", int'(sweep_active), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
